// File: rtl/if_hazard_ctrl.sv
// if_hazard_ctrl: IF-stage redirect/stall/trap arbiter with irq holdoff; IF_HAZARD_CTRL_STALL_CNT_EN enables stall_count
module if_hazard_ctrl #(
  parameter int unsigned TRAP_HOLDOFF = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_busy,
  input  logic        exception_req,
  input  logic        irq_req,
  input  logic        kernel_mode,
  input  logic        branch_EX,
  input  logic        jr_ID,
  input  logic        jump_ID,
  input  logic        load_use,
  output logic [3:0]  PC_Src,
  output logic        IF_Flush,
  output logic        IF_Pause,
  output logic        ID_Flush,
  output logic        ID_Pause,
  output logic        EX_Flush,
  output logic        intruption,
  output logic        exception,
  output logic        irq_ack,
  output logic [31:0] stall_count
);
  typedef enum logic {RUN, TRAP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic irq_pending, take;
  assign take = state == RUN && irq_pending && !kernel_mode && !(branch_EX || jr_ID || jump_ID || load_use);
  always_comb begin
    PC_Src = 4'd0;
    IF_Flush = 1'b0;
    IF_Pause = 1'b0;
    ID_Flush = 1'b0;
    ID_Pause = 1'b0;
    EX_Flush = 1'b0;
    intruption = 1'b0;
    exception = 1'b0;
    irq_ack = 1'b0;
    state_n = state;
    cnt_n = cnt;
    if (!reset) begin
      if (mem_busy) begin
        IF_Pause = 1'b1;
        ID_Pause = 1'b1;
      end else if (exception_req) begin
        exception = 1'b1;
        IF_Flush = 1'b1;
        ID_Flush = 1'b1;
        EX_Flush = 1'b1;
        state_n = TRAP;
        cnt_n = 4'(TRAP_HOLDOFF);
      end else begin
        if (state == TRAP) begin
          state_n = cnt <= 4'd1 ? RUN : TRAP;
          cnt_n = cnt <= 4'd1 ? 4'd0 : cnt - 4'd1;
        end
        if (take) begin
          intruption = 1'b1;
          irq_ack = 1'b1;
          IF_Flush = 1'b1;
          ID_Flush = 1'b1;
          state_n = TRAP;
          cnt_n = 4'(TRAP_HOLDOFF);
        end else if (branch_EX) begin
          PC_Src = 4'd1;
          IF_Flush = 1'b1;
          ID_Flush = 1'b1;
        end else if (jr_ID) begin
          PC_Src = 4'd3;
          IF_Flush = 1'b1;
        end else if (jump_ID) begin
          PC_Src = 4'd2;
          IF_Flush = 1'b1;
        end else if (load_use) begin
          IF_Pause = 1'b1;
          ID_Flush = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt <= 4'd0;
      irq_pending <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      irq_pending <= !irq_ack && (irq_pending || irq_req);
    end
  end
`ifdef IF_HAZARD_CTRL_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (reset) stall_q <= 32'd0;
    else if (IF_Pause && !(&stall_q)) stall_q <= stall_q + 32'd1;
  end
  assign stall_count = reset ? 32'd0 : stall_q;
`else
  assign stall_count = 32'd0;
`endif
endmodule

// File: doc/if_hazard_ctrl.md
# if_hazard_ctrl

Pipeline control unit that sequences the instruction-fetch stage. It arbitrates redirect, stall and trap requests from ID, EX and the memory system each cycle. It drives the fetch stage's `PC_Src`, `IF_Flush`, `IF_Pause`, `intruption` and `exception` inputs, plus the ID/EX flush and pause controls. It also latches external interrupts and releases them only at a safe pipeline point.

## Interface
- `TRAP_HOLDOFF`, default 3: cycles after a trap during which interrupts are masked (1..15).
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `mem_busy` in 1: data/instruction memory not ready; freeze fetch and decode.
- `exception_req` in 1: exception raised by any stage.
- `irq_req` in 1: external interrupt, level.
- `kernel_mode` in 1: bit 31 of the PC currently in ID; interrupts are not taken when set.
- `branch_EX` in 1: taken branch resolved in EX.
- `jr_ID` in 1: jr decoded in ID.
- `jump_ID` in 1: j/jal decoded in ID.
- `load_use` in 1: load-use hazard detected in ID.
- `PC_Src` out 4: 0 = PC+4, 1 = branch, 2 = jump, 3 = jr.
- `IF_Flush`, `IF_Pause` out 1 each: fetch-stage controls.
- `ID_Flush`, `ID_Pause` out 1 each: ID/EX register controls.
- `EX_Flush` out 1: EX/MEM register control.
- `intruption`, `exception` out 1 each: trap vector select to fetch.
- `irq_ack` out 1: one-cycle acknowledge of the taken interrupt.
- `stall_count` out 32: fetch stall cycle counter (see Configuration).

## Operation
- The FSM has two states, RUN and TRAP. Internal registers are a 4-bit holdoff counter `cnt` and an `irq_pending` latch.
- `irq_pending` is set on any cycle with `irq_req`=1. It is cleared in the cycle `irq_ack`=1; if the clear and `irq_req`=1 coincide, clear wins.
- All outputs are combinational from the inputs and current state. The following per-cycle priority applies in both states, first match wins:
  1. `mem_busy`: `IF_Pause`=`ID_Pause`=1 and all other controls 0. Upstream stages hold their requests stable while this is asserted.
  2. `exception_req`: `exception`=1; `IF_Flush`, `ID_Flush`, `EX_Flush`=1. Next state TRAP, `cnt`←`TRAP_HOLDOFF`. This also applies in TRAP, where it reloads `cnt`.
  3. Interrupt take, when state=RUN, `irq_pending`=1, `kernel_mode`=0, and `branch_EX`, `jr_ID`, `jump_ID`, `load_use` are all 0:
     - `intruption`=1, `irq_ack`=1, `IF_Flush`=`ID_Flush`=1.
     - Next state TRAP, `cnt`←`TRAP_HOLDOFF`.
  4. `branch_EX`: `PC_Src`=1, `IF_Flush`=`ID_Flush`=1.
  5. `jr_ID`: `PC_Src`=3, `IF_Flush`=1. This also applies when `jump_ID` is asserted simultaneously (illegal; jr wins).
  6. `jump_ID`: `PC_Src`=2, `IF_Flush`=1.
  7. `load_use`: `IF_Pause`=1, `ID_Flush`=1 (one bubble).
  8. Otherwise `PC_Src`=0 and all controls 0.
- TRAP state:
  - Decrements `cnt` each cycle not frozen by `mem_busy`.
  - Returns to RUN on the clock edge where `cnt`==1 and no new exception is present.
  - Interrupts stay pending but are not taken while in TRAP.
- `PC_Src` values 4..15 are never produced.

## Timing
- Control outputs respond to inputs with zero latency, in the same cycle. State, `cnt`, `irq_pending` and `stall_count` update on the rising edge of `clk`.
- Interrupt latency:
  - A pulse of `irq_req` in cycle N is latched at edge N.
  - It can be taken in cycle N+1 at the earliest.
  - Each cycle that matches a higher-priority rule, or that has `kernel_mode`=1, delays it by one cycle.
- After a trap, the earliest next interrupt take is `TRAP_HOLDOFF`+1 cycles later.
- `reset`=1:
  - All outputs are forced to 0 in that cycle, including `stall_count`.
  - At the edge: state←RUN, `cnt`←0, `irq_pending`←0.
  - A trap in progress is abandoned.

## Configuration
- `IF_HAZARD_CTRL_STALL_CNT_EN` defined:
  - `stall_count` increments on each edge where `IF_Pause`=1 and `reset`=0.
  - It saturates at 32'hFFFF_FFFF and is cleared only by reset.
- `IF_HAZARD_CTRL_STALL_CNT_EN` undefined: the port exists, is tied to 32'd0, and has no counter flops.

## Test plan
- Reset check: after reset, idle inputs → `PC_Src`=0 and all flush/pause outputs 0. Assert `load_use` 1 cycle → `IF_Pause`=1, `ID_Flush`=1 for exactly that cycle.
- Redirect arbitration: `branch_EX`=1 with `jr_ID`=1 → `PC_Src`=1 with `IF_Flush`=`ID_Flush`=1. `jr_ID`=`jump_ID`=1 → `PC_Src`=3.
- Interrupt deferral:
  - Pulse `irq_req` with `kernel_mode`=1 for 5 cycles: no `intruption`.
  - Drop `kernel_mode` → `intruption`=`irq_ack`=1 for exactly one cycle.
  - A second `irq_req` is not taken for 3 cycles afterwards (`TRAP_HOLDOFF`=3).
- Freeze and override:
  - `mem_busy`=1 with `exception_req`=1 → only `IF_Pause`=`ID_Pause`=1.
  - Next cycle, `mem_busy`=0 → `exception`=1 and all three flushes 1, overriding a pending interrupt.
- Reset mid-trap: assert `reset` while `cnt`=2 → state RUN, `irq_pending`=0. With `IF_HAZARD_CTRL_STALL_CNT_EN` defined, 7 pause cycles give `stall_count`=7, and reset returns it to 0.
